// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and priority-encoder helper for the keypad
// code queue.
package kbd_pkg;

    localparam int KEYS    = 16;
    localparam int CODE_W  = $clog2(KEYS);
    localparam int DEPTH   = 8;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    // Index of the lowest set bit; callers only use it when mask is non-zero.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [KEYS-1:0] mask);
        lowest_set = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/keyboard_code_fifo_if.sv
// First-word-fall-through read port of the key code queue; the reader (CPU/UART)
// is the master, the queue is the slave.
interface keyboard_code_fifo_if;
    import kbd_pkg::*;

    logic               rd_en;
    logic [CODE_W-1:0]  rd_data;
    logic               rd_valid;
    logic [LEVEL_W-1:0] level;

    modport master (output rd_en, input rd_data, rd_valid, level);
    modport slave  (input rd_en, output rd_data, rd_valid, level);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with wrapping pointers and a separate occupancy count;
// a push into a full FIFO succeeds when a pop happens at the same edge.
module sync_fifo #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is left unreset; entries are only visible once the count
    // covers them, so reset only needs to clear pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Head is shown directly from storage; forced to zero when nothing is queued.
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/keyboard_code_fifo.sv
// Snapshots the sticky key bitmask, acknowledges it with key_clear, and drains
// the snapshot lowest key first into a code FIFO read through a FWFT port.
module keyboard_code_fifo
    import kbd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEYS-1:0]       key_data,
    output logic                  key_clear,
    keyboard_code_fifo_if.slave   rd,
    output logic                  busy
);

    state_t            state;
    state_t            state_next;
    logic [KEYS-1:0]   snap;
    logic [KEYS-1:0]   snap_next;
    logic [KEYS-1:0]   snap_cleared;
    logic [CODE_W-1:0] code;
    logic              accept;
    logic              push;
    logic              full;
    logic              empty;

    assign code         = lowest_set(snap);
    assign snap_cleared = snap & ~(KEYS'(1) << code);
    // A pop at the same edge frees the slot a full FIFO needs.
    assign accept       = !full || rd.rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            snap  <= '0;
        end else begin
            state <= state_next;
            snap  <= snap_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        snap_next  = snap;
        push       = 1'b0;
        key_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (key_data != '0) begin
                    key_clear  = !rst;
                    snap_next  = key_data;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    push      = 1'b1;
                    snap_next = snap_cleared;
                    if (snap_cleared == '0) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy        = (state == DRAIN);
    assign rd.rd_valid = !empty;

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (code),
        .pop       (rd.rd_en),
        .rd_data   (rd.rd_data),
        .full      (full),
        .empty     (empty),
        .count     (rd.level)
    );

endmodule
